// File: rtl/issue_ctrl_if.sv
// Decode-side bundle for issue_ctrl: instruction sources/destination,
// writeback retire port, drain request and the issue-gating outputs.
// The master drives the instruction stream; the slave is issue_ctrl.
interface issue_ctrl_if;
  logic        issue_valid;
  logic        fmode1;
  logic        fmode2;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic        dst_wr;
  logic        dst_f;
  logic [4:0]  dst_no;
  logic        wb_valid;
  logic        wb_f;
  logic [4:0]  wb_no;
  logic        drain_req;
  logic        dec_enable;
  logic        stall;
  logic        drained;
  logic [3:0]  outst;
  logic [31:0] stall_cnt;

  modport master (
    output issue_valid, fmode1, fmode2, reg1, reg2, dst_wr, dst_f, dst_no,
           wb_valid, wb_f, wb_no, drain_req,
    input  dec_enable, stall, drained, outst, stall_cnt
  );

  modport slave (
    input  issue_valid, fmode1, fmode2, reg1, reg2, dst_wr, dst_f, dst_no,
           wb_valid, wb_f, wb_no, drain_req,
    output dec_enable, stall, drained, outst, stall_cnt
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue controller: scoreboard of in-flight integer/float destination
// registers gating the decode enable, plus a RUN/DRAIN/DONE drain FSM.
// Optional feature: define ISSUE_CTRL_BYPASS_EN to let a writeback mask the
// hazard on the register it retires in the same cycle (sources and WAW).
module issue_ctrl #(
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic       clk,
  input  logic       rstn,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_t      state_q, state_d;
  logic [31:0] busy_i, busy_f;
  logic [3:0]  outst_q;
  logic [31:0] stall_cnt_q;

  logic [31:0] wb_mask_i, wb_mask_f;
  logic [31:0] byp_i, byp_f;
  logic [31:0] haz_i, haz_f;
  logic [31:0] acc_mask_i, acc_mask_f;
  logic        wb_hit, accept;
  logic        src_haz, waw_haz, full, hazard;
  logic        dec_enable_w, stall_w, drained_w;

  // Decode the retiring write; only a busy register with outst>0 retires.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wb_mask_i = '0;
    wb_mask_f = '0;
    if (bus.wb_valid && (outst_q != 4'd0)) begin
      if (bus.wb_f) wb_mask_f = busy_f & (32'd1 << bus.wb_no);
      else          wb_mask_i = busy_i & (32'd1 << bus.wb_no);
    end
  end

  assign wb_hit = |{wb_mask_i, wb_mask_f};

`ifdef ISSUE_CTRL_BYPASS_EN
  assign byp_i = wb_mask_i;
  assign byp_f = wb_mask_f;
`else
  assign byp_i = '0;
  assign byp_f = '0;
`endif

  // Busy bits as seen by hazard detection (after optional same-cycle bypass).
  assign haz_i = busy_i & ~byp_i;
  assign haz_f = busy_f & ~byp_f;

  assign src_haz = (bus.fmode1 ? haz_f[bus.reg1] : haz_i[bus.reg1]) |
                   (bus.fmode2 ? haz_f[bus.reg2] : haz_i[bus.reg2]);
  assign waw_haz = bus.dst_wr & (bus.dst_f ? haz_f[bus.dst_no] : haz_i[bus.dst_no]);
  assign full    = bus.dst_wr & (outst_q == MAX_CNT);
  assign hazard  = src_haz | waw_haz | full;

  // Integer r0 is hardwired, so a write to it is neither tracked nor counted.
  assign accept     = dec_enable_w & bus.dst_wr & (bus.dst_f | (bus.dst_no != 5'd0));
  assign acc_mask_i = (accept && !bus.dst_f) ? (32'd1 << bus.dst_no) : '0;
  assign acc_mask_f = (accept &&  bus.dst_f) ? (32'd1 << bus.dst_no) : '0;

  // Scoreboard and outstanding count: retire first, then set the new owner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the busy vectors are control state, not a RAM; they must reset or stale bits would block issue forever.
      busy_i  <= '0;
      busy_f  <= '0;
      outst_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      busy_i <= (busy_i & ~wb_mask_i) | acc_mask_i;
      busy_f <= (busy_f & ~wb_mask_f) | acc_mask_f;
      if (accept && !wb_hit)      outst_q <= outst_q + 4'd1;
      else if (!accept && wb_hit) outst_q <= outst_q - 4'd1;
    end
  end

  // Free-running count of stalled cycles, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_q + {31'd0, stall_w};
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Drain FSM next state; dropping the request always returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (!bus.drain_req)          state_d = ST_RUN;
                else if (outst_q == 4'd0)    state_d = ST_DONE;
      ST_DONE:  if (!bus.drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Issue outputs: zero-latency from state and inputs, forced low in reset.
  always_comb begin
    dec_enable_w = 1'b0;
    stall_w      = 1'b0;
    drained_w    = 1'b0;
    if (rstn) begin
      case (state_q)
        ST_RUN: begin
          dec_enable_w = bus.issue_valid & ~hazard;
          stall_w      = bus.issue_valid & hazard;
        end
        ST_DRAIN: begin
          stall_w   = bus.issue_valid;
          drained_w = (outst_q == 4'd0);
        end
        ST_DONE: begin
          stall_w   = bus.issue_valid;
          drained_w = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dec_enable = dec_enable_w;
  assign bus.stall      = stall_w;
  assign bus.drained    = drained_w;
  assign bus.outst      = outst_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed vector table, hand-written full/drain/
// reset sequences, and randomized traffic against a queue-based model.
module tb_issue_ctrl;

`ifdef ISSUE_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAX = 8;

  logic clk;
  logic rstn;
  issue_ctrl_if bus();

  issue_ctrl #(.MAX_OUTST(MAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv, f1;
    logic [4:0] r1;
    logic       f2;
    logic [4:0] r2;
    logic       dw, df;
    logic [4:0] dn;
    logic       wv, wf;
    logic [4:0] wn;
    logic       dr;
    logic       en, st, dd;
    int         os;
  } vec_t;

  typedef struct packed {
    logic       f;
    logic [4:0] no;
  } reg_t;

  int   checks;
  int   failures;
  int   exp_stalls;
  reg_t outq[$];
  int   m_mode;   // 0 run, 1 draining, 2 drained
  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic f1, input logic [4:0] r1,
                              input logic f2, input logic [4:0] r2,
                              input logic dw, input logic df, input logic [4:0] dn,
                              input logic wv, input logic wf, input logic [4:0] wn,
                              input logic dr, input logic en, input logic st,
                              input logic dd, input int os);
    vec_t v;
    v.iv = iv; v.f1 = f1; v.r1 = r1; v.f2 = f2; v.r2 = r2;
    v.dw = dw; v.df = df; v.dn = dn; v.wv = wv; v.wf = wf; v.wn = wn;
    v.dr = dr; v.en = en; v.st = st; v.dd = dd; v.os = os;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv; bus.fmode1 = v.f1; bus.reg1 = v.r1;
    bus.fmode2 = v.f2; bus.reg2 = v.r2;
    bus.dst_wr = v.dw; bus.dst_f = v.df; bus.dst_no = v.dn;
    bus.wb_valid = v.wv; bus.wb_f = v.wf; bus.wb_no = v.wn;
    bus.drain_req = v.dr;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check({tag, " dec_enable"}, 32'(bus.dec_enable), 32'(v.en));
    check({tag, " stall"},      32'(bus.stall),      32'(v.st));
    check({tag, " drained"},    32'(bus.drained),    32'(v.dd));
    check({tag, " outst"},      32'(bus.outst),      32'(v.os));
    if (v.st) exp_stalls++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(1, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    rstn = 1'b0;
    @(negedge clk);
    check("rst dec_enable", 32'(bus.dec_enable), 32'd0);
    check("rst stall",      32'(bus.stall),      32'd0);
    check("rst drained",    32'(bus.drained),    32'd0);
    check("rst outst",      32'(bus.outst),      32'd0);
    check("rst stall_cnt",  bus.stall_cnt,       32'd0);
    rstn = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    outq.delete();
    m_mode     = 0;
    exp_stalls = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic bit owned(input logic f, input logic [4:0] n);
    foreach (outq[k]) if (outq[k].f == f && outq[k].no == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit blk(input logic f, input logic [4:0] n, input bit retire,
                             input logic wf, input logic [4:0] wn);
    return owned(f, n) && !(BYP && retire && wf == f && wn == n);
  endfunction

  task automatic run_random(input int cycles);
    vec_t v;
    bit   retire, haz;
    logic dr;
    int   size_now;
    dr = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      v.iv = ($urandom_range(0, 3) != 0);
      v.f1 = 1'($urandom_range(0, 1)); v.r1 = 5'($urandom_range(0, 7));
      v.f2 = 1'($urandom_range(0, 1)); v.r2 = 5'($urandom_range(0, 7));
      v.dw = 1'($urandom_range(0, 1));
      v.df = 1'($urandom_range(0, 1)); v.dn = 5'($urandom_range(0, 7));
      v.wv = ($urandom_range(0, 4) < 2);
      if (outq.size() > 0 && $urandom_range(0, 4) != 0) begin
        int idx;
        idx  = int'($urandom_range(0, outq.size() - 1));
        v.wf = outq[idx].f;
        v.wn = outq[idx].no;
      end else begin
        v.wf = 1'($urandom_range(0, 1));
        v.wn = 5'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 39) == 0) dr = ~dr;
      v.dr = dr;
      drive(v);
      @(negedge clk);
      size_now = outq.size();
      retire = v.wv && owned(v.wf, v.wn);
      haz = blk(v.f1, v.r1, retire, v.wf, v.wn) || blk(v.f2, v.r2, retire, v.wf, v.wn) ||
            (v.dw && blk(v.df, v.dn, retire, v.wf, v.wn)) || (v.dw && size_now == MAX);
      v.en = (m_mode == 0) && v.iv && !haz;
      v.st = v.iv && ((m_mode != 0) || haz);
      v.dd = (m_mode != 0) && (size_now == 0);
      check($sformatf("rnd%0d dec_enable", c), 32'(bus.dec_enable), 32'(v.en));
      check($sformatf("rnd%0d stall", c),      32'(bus.stall),      32'(v.st));
      check($sformatf("rnd%0d drained", c),    32'(bus.drained),    32'(v.dd));
      check($sformatf("rnd%0d outst", c),      32'(bus.outst),      32'(size_now));
      @(posedge clk);
      if (retire) begin
        for (int k = 0; k < outq.size(); k++)
          if (outq[k].f == v.wf && outq[k].no == v.wn) begin
            outq.delete(k);
            break;
          end
      end
      if (v.en && v.dw && (v.df || v.dn != 5'd0)) outq.push_back({v.df, v.dn});
      if (v.st) exp_stalls++;
      if (!v.dr)                          m_mode = 0;
      else if (m_mode == 0)               m_mode = 1;
      else if (m_mode == 1 && size_now == 0) m_mode = 2;
      #1;
    end
    @(negedge clk);
    check("rnd stall_cnt", bus.stall_cnt, 32'(exp_stalls));
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;

    // Directed vectors: iv f1 r1 f2 r2 dw df dn wv wf wn dr | en st dd os
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b0, 1'b0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0,  1'b1, 1'b0, 0, 0);
    tbl[2]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b0, 1'b1, 0, 1);
    tbl[3]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b1, 1'b0, 0, 1);
    tbl[4]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 5, 0,  BYP, !BYP, 0, 1);
    tbl[5]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b1, 1'b0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1'b1, 1'b0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b1, 1'b0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0,  1'b1, 1'b0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0,  1'b1, 1'b0, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 1, 3, 1, 1, 3, 0,  BYP, !BYP, 0, 2);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b0, 1'b0, 0, BYP ? 2 : 1);
    tbl[12] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,  !BYP, BYP, 0, BYP ? 2 : 1);
    tbl[13] = mk(1, 0, 0, 0, 7, 0, 0, 0, 1, 0, 7, 0,  BYP, !BYP, 0, BYP ? 2 : 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0,  1'b0, 1'b0, 0, BYP ? 1 : 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0,  1'b0, 1'b0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1'b0, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < 17; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));
    @(negedge clk);
    check("vec stall_cnt", bus.stall_cnt, 32'(exp_stalls));
    @(posedge clk);
    #1;

    // Full: MAX writes accepted, next write held while a non-writer issues.
    do_reset();
    for (int i = 1; i <= MAX; i++)
      apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 5'(i), 0, 0, 0, 0, 1, 0, 0, i - 1), $sformatf("fill%0d", i));
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 1, 0, MAX), "full wr");
    apply_vec(mk(1, 0, 20, 0, 21, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MAX), "full nonwr");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 9, 1, 0, 1, 0, 0, 1, 0, MAX), "full wb same");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 1, 0, 0, MAX - 1), "full after wb");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MAX), "full idle");

    // Drain with three outstanding writes, then resume.
    do_reset();
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "dr w1");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 0, 0, 1), "dr w2");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2), "dr w3");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3), "dr req");
    apply_vec(mk(1, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3), "dr blocked");
    apply_vec(mk(1, 0, 20, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 3), "dr wb1");
    apply_vec(mk(1, 0, 20, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1, 0, 2), "dr wb2");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0, 0, 1), "dr wb3");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), "dr empty");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1, 0, 1, 1, 0), "dr done");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 1, 1, 0), "dr drop");
    apply_vec(mk(1, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0), "dr resume");
    apply_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "dr idle");
    @(negedge clk);
    check("dr stall_cnt", bus.stall_cnt, 32'(exp_stalls));
    @(posedge clk);
    #1;

    // Reset mid-operation: int r4 is busy and a reader is stalled.
    drive(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rstn = 1'b0;
    #1;
    check("midrst dec_enable", 32'(bus.dec_enable), 32'd0);
    check("midrst stall",      32'(bus.stall),      32'd0);
    check("midrst outst",      32'(bus.outst),      32'd0);
    check("midrst stall_cnt",  bus.stall_cnt,       32'd0);
    @(negedge clk);
    rstn = 1'b1;
    exp_stalls = 0;
    outq.delete();
    m_mode = 0;
    @(posedge clk);
    #1;
    apply_vec(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "midrst reader");

    do_reset();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
